sap_alu_seq_bh: RTL and testbench
=================================

// Module: sap_alu_seq_bh
// PURPOSE
//   Registered, parametrised ALU for the SAP-2 datapath; successor to the SAP-1 adder-subtractor.
//   Performs ADD/SUB/logic/compare/add-with-carry in one clock and an unsigned multiply in WIDTH clocks.
//   Holds RESULT and a flag register (Z,S,C,V) for the controller's conditional jumps.
//   Sits between the accumulator/B/TMP registers and the W-bus, under START/BUSY/DONE handshake.
// PARAMETERS
//   WIDTH   8   operand/result width in bits, >= 4
//   MUL_EN  1   1 = op MUL implemented; 0 = MUL decoded as NOP
// PORTS
//   CLK        in   1      system clock, all state on rising edge
//   CLR        in   1      synchronous active-high reset
//   START      in   1      request; sampled only when BUSY=0
//   OP         in   3      operation code (sap_alu_pkg::alu_op_t)
//   A          in   WIDTH  operand A (accumulator)
//   B          in   WIDTH  operand B
//   RESULT     out  WIDTH  registered result (MUL: low half)
//   RESULT_HI  out  WIDTH  MUL high half; 0 after all other ops
//   FLAGS      out  4      {Z,S,C,V}, registered
//   BUSY       out  1      multiply in progress
//   DONE       out  1      1-cycle pulse: RESULT/FLAGS just updated
// BEHAVIOUR
//   Clock/reset: one clock CLK; CLR synchronous, active-high, priority over everything incl. START.
//   Reset: RESULT=0, RESULT_HI=0, FLAGS=0, BUSY=0, DONE=0, FSM=IDLE; aborts any MUL, no DONE.
//   OP: 000 ADD A+B | 001 SUB A-B | 010 AND | 011 OR | 100 XOR | 101 CMP (A-B, flags only,
//     RESULT/RESULT_HI unchanged) | 110 MUL unsigned A*B | 111 ADC A+B+C(stored flag).
//   Arithmetic in WIDTH+1 bits; RESULT = low WIDTH bits, modulo wrap, no saturation.
//   Flags: Z = RESULT==0 (CMP: difference==0); S = msb of result/difference;
//     C = carry-out (ADD/ADC), borrow (SUB/CMP: 1 when A<B unsigned), 0 for logic ops;
//     V = signed overflow (ADD/ADC/SUB/CMP), 0 for logic ops.
//     MUL: Z = full 2*WIDTH product==0, S = RESULT_HI msb, C = RESULT_HI!=0, V = 0.
//   FSM states: IDLE, MUL.
//     IDLE & START & OP!=MUL: at that edge RESULT/RESULT_HI/FLAGS load, DONE=1 for the next cycle.
//     IDLE & START & OP==MUL & MUL_EN: latch A,B, clear product, counter=0, BUSY=1, -> MUL.
//     MUL: one shift-add step per edge; on step WIDTH (edge WIDTH after acceptance) write
//       RESULT/RESULT_HI/FLAGS, BUSY=0, DONE=1, -> IDLE. Latency 1 (simple ops), WIDTH (MUL).
//     MUL with MUL_EN=0: NOP, outputs and flags held, DONE still pulses.
//   START while BUSY=1: ignored, not queued. Operand changes during MUL: no effect (latched).
//   Back-to-back: START may be high on the DONE cycle and is accepted (BUSY=0).
//   DONE never high with BUSY; DONE is 0 every cycle without a completion.
//   Outputs hold their value between operations.
// STRUCTURE
//   sap_alu_pkg: alu_op_t enum (3 bits), flags_t packed struct {z,s,c,v}, flag bit index localparams.
//   Sub-module shift_add_mul_bh (#WIDTH): latched operands, step counter, 2*WIDTH product,
//     start/busy/done; this block owns the FSM, decode, flag logic and output registers.
// TESTING
//   CLR then ADD A=8'h7F,B=8'h01 -> next cycle RESULT=8'h80, FLAGS Z0 S1 C0 V1, DONE pulse 1 cycle.
//   SUB A=8'h05,B=8'h07 -> RESULT=8'hFE, C=1(borrow), S=1; then CMP 8'h05,8'h05 -> Z=1, RESULT stays 8'hFE.
//   ADD 8'hFF+8'h01 (C=1) then ADC 8'h10+8'h20 -> RESULT=8'h31, C=0.
//   MUL 8'hFF*8'hFF -> BUSY 8 cycles, then RESULT=8'h01, RESULT_HI=8'hFE, C=1; START while BUSY ignored.
//   CLR asserted at MUL step 4 -> next cycle all outputs 0, BUSY=0, no DONE; following ADD 3+4 gives 7.
//   WIDTH=16, MUL_EN=0: OP=110 -> DONE pulse, RESULT/FLAGS unchanged; ADD 16'hFFFF+1 -> Z=1, C=1.

Source files
------------

// File: rtl/sap_alu_pkg.sv
// Shared types for the SAP-2 ALU: opcode enum, flag register layout, flag bit indices.
// Pure declarations, no logic and no latency.
// No backpressure of its own.
package sap_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_CMP = 3'b101,
    OP_MUL = 3'b110,
    OP_ADC = 3'b111
  } alu_op_t;

  // Bit order matches the FLAGS port: {Z,S,C,V}
  typedef struct packed {
    logic z;
    logic s;
    logic c;
    logic v;
  } flags_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_S = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/sap_alu_seq_bh_mul.sv
// Unsigned shift-add multiplier: latches operands, one partial product per clock.
// Latency WIDTH clocks from start; done_o/prod_o are combinational on the last step edge.
// start_i is ignored while busy_o is high; no queuing.
module shift_add_mul_bh #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // Next partial sum; on the final step this is the full product the parent registers
  always_comb begin
    prod_d = prod_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign prod_o = prod_d;

  // Operand latch on accept, then shift multiplicand left / multiplier right each step
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i && !busy_q) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sap_alu_seq_bh.sv
// Registered SAP-2 ALU: ADD/SUB/logic/CMP/ADC plus unsigned multiply, with {Z,S,C,V} flags.
// Latency 1 clock for simple ops, WIDTH clocks for MUL; DONE pulses one cycle on completion.
// START is sampled only while BUSY=0; requests during a multiply are dropped.
module sap_alu_seq_bh
  import sap_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic [3:0]       FLAGS,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  flags_t             flags_q, flags_d;
  logic               done_q, done_d;

  alu_op_t            op_w;
  logic               carry_in;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic               add_v;
  logic               sub_v;
  logic [WIDTH-1:0]   logic_w;

  logic               mul_go;
  logic               mul_busy;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_prod;

  assign op_w = alu_op_t'(OP);

  shift_add_mul_bh #(.WIDTH(WIDTH)) u_mul (
    .clk_i   (CLK),
    .clr_i   (CLR),
    .start_i (mul_go),
    .a_i     (A),
    .b_i     (B),
    .busy_o  (mul_busy),
    .done_o  (mul_last),
    .prod_o  (mul_prod)
  );

  // Single-cycle datapath: adder (ADC folds in the stored carry), subtractor, logic unit
  always_comb begin
    carry_in = (op_w == OP_ADC) ? flags_q.c : 1'b0;
    add_w    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, carry_in};
    sub_w    = {1'b0, A} - {1'b0, B};
    add_v    = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
    sub_v    = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
    case (op_w)
      OP_OR:   logic_w = A | B;
      OP_XOR:  logic_w = A ^ B;
      default: logic_w = A & B;
    endcase
  end

  // FSM next state, op decode and next values of the output registers
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    done_d      = 1'b0;
    mul_go      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START && !mul_busy) begin
          done_d = 1'b1;
          case (op_w)
            OP_ADD, OP_ADC: begin
              result_d    = add_w[WIDTH-1:0];
              result_hi_d = '0;
              flags_d.z   = (add_w[WIDTH-1:0] == '0);
              flags_d.s   = add_w[WIDTH-1];
              flags_d.c   = add_w[WIDTH];
              flags_d.v   = add_v;
            end
            OP_SUB, OP_CMP: begin
              // CMP only touches the flags
              if (op_w == OP_SUB) begin
                result_d    = sub_w[WIDTH-1:0];
                result_hi_d = '0;
              end
              flags_d.z = (sub_w[WIDTH-1:0] == '0);
              flags_d.s = sub_w[WIDTH-1];
              flags_d.c = sub_w[WIDTH];
              flags_d.v = sub_v;
            end
            OP_MUL: begin
              // Without a multiplier this is a NOP that still acknowledges
              if (MUL_EN != 0) begin
                mul_go  = 1'b1;
                done_d  = 1'b0;
                state_d = ST_MUL;
              end
            end
            default: begin
              result_d    = logic_w;
              result_hi_d = '0;
              flags_d.z   = (logic_w == '0);
              flags_d.s   = logic_w[WIDTH-1];
              flags_d.c   = 1'b0;
              flags_d.v   = 1'b0;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          result_d    = mul_prod[WIDTH-1:0];
          result_hi_d = mul_prod[2*WIDTH-1:WIDTH];
          flags_d.z   = (mul_prod == '0);
          flags_d.s   = mul_prod[2*WIDTH-1];
          flags_d.c   = (mul_prod[2*WIDTH-1:WIDTH] != '0);
          flags_d.v   = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; CLR wins over everything and suppresses DONE
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      done_q      <= done_d;
    end
  end

  assign RESULT    = result_q;
  assign RESULT_HI = result_hi_q;
  assign FLAGS     = flags_q;
  assign BUSY      = (state_q == ST_MUL);
  assign DONE      = done_q;

endmodule

// File: tb/tb_sap_alu_seq_bh.sv
// Bench for sap_alu_seq_bh: an 8-bit MUL-capable instance and a 16-bit instance without MUL.
// Directed literal checks, then randomized traffic against a behavioural model.
// Model compared to both DUTs on every falling edge.
module tb_sap_alu_seq_bh;

  typedef struct {
    longint   res;
    longint   hi;
    logic [3:0] flags;
    int       cnt;
    bit       done;
    longint   ma;
    longint   mb;
  } model_t;

  logic clk;
  logic clr8, start8, busy8, done8;
  logic [2:0] op8;
  logic [7:0] a8, b8, res8, hi8;
  logic [3:0] flg8;
  logic clr16, start16, busy16, done16;
  logic [2:0] op16;
  logic [15:0] a16, b16, res16, hi16;
  logic [3:0] flg16;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  model_t m8, m16;

  sap_alu_seq_bh #(.WIDTH(8), .MUL_EN(1)) dut8 (
    .CLK(clk), .CLR(clr8), .START(start8), .OP(op8), .A(a8), .B(b8),
    .RESULT(res8), .RESULT_HI(hi8), .FLAGS(flg8), .BUSY(busy8), .DONE(done8)
  );

  sap_alu_seq_bh #(.WIDTH(16), .MUL_EN(0)) dut16 (
    .CLK(clk), .CLR(clr16), .START(start16), .OP(op16), .A(a16), .B(b16),
    .RESULT(res16), .RESULT_HI(hi16), .FLAGS(flg16), .BUSY(busy16), .DONE(done16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural reference: one clock edge of the ALU as plain integer arithmetic
  function automatic model_t step(model_t m, int w, bit mul_en, bit clr, bit start,
                                  int op, longint a, longint b);
    model_t n;
    longint mask, half, r, sa, sb, sr, p, d;
    longint cin;
    n = m;
    n.done = 0;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    if (clr) begin
      n.res = 0; n.hi = 0; n.flags = 4'b0000; n.cnt = 0; n.ma = 0; n.mb = 0;
      return n;
    end
    if (m.cnt > 0) begin
      n.cnt = m.cnt - 1;
      if (n.cnt == 0) begin
        p = m.ma * m.mb;
        n.res = p & mask;
        n.hi  = (p >> w) & mask;
        n.flags = {p == 0, n.hi >= half, n.hi != 0, 1'b0};
        n.done = 1;
      end
      return n;
    end
    if (!start) return n;
    n.done = 1;
    sa = (a >= half) ? a - (mask + 1) : a;
    sb = (b >= half) ? b - (mask + 1) : b;
    case (op)
      0, 7: begin
        cin = (op == 7) ? longint'(m.flags[1]) : 0;
        r  = a + b + cin;
        sr = sa + sb + cin;
        n.res = r & mask;
        n.hi  = 0;
        n.flags = {n.res == 0, n.res >= half, r > mask, (sr >= half) || (sr < -half)};
      end
      1, 5: begin
        r  = a - b;
        sr = sa - sb;
        d  = r & mask;
        if (op == 1) begin
          n.res = d;
          n.hi  = 0;
        end
        n.flags = {d == 0, d >= half, a < b, (sr >= half) || (sr < -half)};
      end
      2, 3, 4: begin
        r = (op == 2) ? (a & b) : (op == 3) ? (a | b) : (a ^ b);
        n.res = r;
        n.hi  = 0;
        n.flags = {r == 0, r >= half, 1'b0, 1'b0};
      end
      default: begin
        if (mul_en) begin
          n.ma = a; n.mb = b; n.cnt = w; n.done = 0;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    m8  = step(m8, 8, 1'b1, clr8, start8, int'(op8), longint'(a8), longint'(b8));
    m16 = step(m16, 16, 1'b0, clr16, start16, int'(op16), longint'(a16), longint'(b16));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Pin DUT and model together to a hand-computed value
  task automatic pin(input string nm, input logic [63:0] dut_v, input logic [63:0] mdl_v,
                     input logic [63:0] exp);
    chk({nm, "_dut"}, dut_v, exp);
    chk({nm, "_model"}, mdl_v, exp);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("res8",  res8,  m8.res);
      chk("hi8",   hi8,   m8.hi);
      chk("flg8",  flg8,  m8.flags);
      chk("busy8", busy8, m8.cnt > 0);
      chk("done8", done8, m8.done);
      chk("res16",  res16,  m16.res);
      chk("hi16",   hi16,   m16.hi);
      chk("flg16",  flg16,  m16.flags);
      chk("busy16", busy16, m16.cnt > 0);
      chk("done16", done16, m16.done);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic do8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic do16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1; op16 = op; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0;
  endtask

  initial begin
    m8 = '{default: 0};
    m16 = '{default: 0};
    clr8 = 1'b1; start8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0;
    clr16 = 1'b1; start16 = 1'b0; op16 = 3'd0; a16 = 16'd0; b16 = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    clr8 = 1'b0; clr16 = 1'b0;
    chk_en = 1;
    pin("rst_res8", res8, m8.res, 0);
    pin("rst_flg8", flg8, m8.flags, 0);
    pin("rst_busy8", busy8, m8.cnt > 0, 0);
    pin("rst_done8", done8, m8.done, 0);

    // Signed overflow into the sign bit
    do8(3'b000, 8'h7F, 8'h01);
    pin("add_res", res8, m8.res, 8'h80);
    pin("add_flg", flg8, m8.flags, 4'b0101);
    pin("add_done", done8, m8.done, 1);
    @(posedge clk); #1;
    pin("add_done_drop", done8, m8.done, 0);

    do8(3'b001, 8'h05, 8'h07);
    pin("sub_res", res8, m8.res, 8'hFE);
    pin("sub_flg", flg8, m8.flags, 4'b0110);
    do8(3'b101, 8'h05, 8'h05);
    pin("cmp_res", res8, m8.res, 8'hFE);
    pin("cmp_flg", flg8, m8.flags, 4'b1000);

    do8(3'b000, 8'hFF, 8'h01);
    pin("addc_flg", flg8, m8.flags, 4'b1010);
    do8(3'b111, 8'h10, 8'h20);
    pin("adc_res", res8, m8.res, 8'h31);
    pin("adc_flg", flg8, m8.flags, 4'b0000);

    do8(3'b010, 8'hF0, 8'h3C);
    pin("and_res", res8, m8.res, 8'h30);

    // Multiply with a competing request mid-flight
    do8(3'b110, 8'hFF, 8'hFF);
    pin("mul_busy0", busy8, m8.cnt > 0, 1);
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) begin start8 = 1'b1; op8 = 3'b000; a8 = 8'h01; b8 = 8'h01; end
      if (k == 5) start8 = 1'b0;
      @(posedge clk); #1;
      pin("mul_busy", busy8, m8.cnt > 0, 1);
      pin("mul_nodone", done8, m8.done, 0);
    end
    @(posedge clk); #1;
    pin("mul_res", res8, m8.res, 8'h01);
    pin("mul_hi", hi8, m8.hi, 8'hFE);
    pin("mul_flg", flg8, m8.flags, 4'b0110);
    pin("mul_done", done8, m8.done, 1);
    pin("mul_idle", busy8, m8.cnt > 0, 0);

    // Reset in the middle of a multiply
    do8(3'b110, 8'h03, 8'h05);
    repeat (3) begin @(posedge clk); #1; end
    clr8 = 1'b1;
    @(posedge clk); #1;
    clr8 = 1'b0;
    pin("clr_res", res8, m8.res, 0);
    pin("clr_hi", hi8, m8.hi, 0);
    pin("clr_busy", busy8, m8.cnt > 0, 0);
    pin("clr_done", done8, m8.done, 0);
    do8(3'b000, 8'h03, 8'h04);
    pin("post_clr_add", res8, m8.res, 8'h07);

    // 16-bit instance without the multiplier
    do16(3'b000, 16'h1234, 16'h0001);
    pin("w16_add", res16, m16.res, 16'h1235);
    do16(3'b110, 16'h0003, 16'h0003);
    pin("w16_nop_res", res16, m16.res, 16'h1235);
    pin("w16_nop_flg", flg16, m16.flags, 4'b0000);
    pin("w16_nop_done", done16, m16.done, 1);
    pin("w16_nop_busy", busy16, m16.cnt > 0, 0);
    do16(3'b000, 16'hFFFF, 16'h0001);
    pin("w16_wrap_res", res16, m16.res, 16'h0000);
    pin("w16_wrap_flg", flg16, m16.flags, 4'b1010);

    // Randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      clr8    = ($urandom_range(0, 63) == 0);
      start8  = ($urandom_range(0, 2) != 0);
      op8     = 3'($urandom_range(0, 7));
      a8      = 8'($urandom);
      b8      = 8'($urandom);
      clr16   = ($urandom_range(0, 63) == 0);
      start16 = ($urandom_range(0, 2) != 0);
      op16    = 3'($urandom_range(0, 7));
      a16     = 16'($urandom);
      b16     = 16'($urandom);
    end
    @(posedge clk); #1;
    start8 = 1'b0; start16 = 1'b0; clr8 = 1'b0; clr16 = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
